btn_pos_ctl: RTL and testbench

- Button-driven position controller upstream of the register overlay stage.
- Synchronizes and debounces four raw player buttons, then applies frame-paced auto-repeat stepping.
- Drives saturating 10-bit x/y positions that feed the overlay's x_pos/y_pos inputs.
- Runs in the pixel-clock domain. Paced by the end-of-frame pulse from the endframe detector.

---
 rtl/btn_pos_ctl_pkg.sv | 26 ++
 rtl/btn_axis_step.sv | 106 ++++++++++
 rtl/btn_pos_ctl.sv | 74 +++++++
 tb/tb_btn_pos_ctl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pos_ctl_pkg.sv
// Shared types and constants for the button-driven position controller.
// Holds the axis FSM encoding and the saturating step helper.
package btn_pos_ctl_pkg;

  localparam int POS_W = 10;
  localparam int CNT_W = 6;
  localparam int DEB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } axis_st_e;

  // Extra carry bit on the up path so an overflow past the clamp cannot wrap.
  function automatic logic [POS_W-1:0] sat_step(input logic [POS_W-1:0] pos,
                                                input logic             up,
                                                input logic [POS_W-1:0] step,
                                                input logic [POS_W-1:0] lim);
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (up) return (sum > {1'b0, lim}) ? lim : sum[POS_W-1:0];
    return (pos < step) ? '0 : pos - step;
  endfunction

endpackage

// File: rtl/btn_axis_step.sv
// One axis: two tick-paced button debouncers, the auto-repeat FSM and the
// saturating position register.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | no direction held; the first debounced direction steps once
// ST_HOLD   | counting down the initial delay before auto-repeat starts
// ST_REPEAT | stepping every REPEAT_RATE ticks while the direction holds
module btn_axis_step
  import btn_pos_ctl_pkg::*;
#(
  parameter logic [POS_W-1:0] MAX          = 10'd639,
  parameter logic [POS_W-1:0] INIT         = 10'd0,
  parameter logic [POS_W-1:0] STEP         = 10'd1,
  parameter int               DEB_FRAMES   = 2,
  parameter int               REPEAT_DELAY = 24,
  parameter int               REPEAT_RATE  = 4
) (
  input  logic             px_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             raw_up,
  input  logic             raw_dn,
  output logic [POS_W-1:0] pos,
  output logic             active
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_FRAMES - 1);
  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);

  axis_st_e              state;
  logic [CNT_W-1:0]      cnt;
  logic                  held_up;
  logic [1:0]            raw, deb, deb_nxt;
  logic [1:0][DEB_W-1:0] dcnt, dcnt_nxt;
  logic                  dir_up, dir_dn, dir_same;

  assign raw = {raw_dn, raw_up};

  always_comb begin
    deb_nxt  = deb;
    dcnt_nxt = dcnt;
    if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == deb[i]) begin
          dcnt_nxt[i] = '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb_nxt[i]  = ~deb[i];
          dcnt_nxt[i] = '0;
        end else begin
          dcnt_nxt[i] = dcnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // The FSM sees the debounced levels as they update on this same tick.
  assign dir_up   = deb_nxt[0] & ~deb_nxt[1];
  assign dir_dn   = deb_nxt[1] & ~deb_nxt[0];
  assign dir_same = held_up ? dir_up : dir_dn;
  assign active   = (state != ST_IDLE);

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      held_up <= 1'b0;
      pos     <= INIT;
      deb     <= '0;
      dcnt    <= '0;
    end else begin
      deb  <= deb_nxt;
      dcnt <= dcnt_nxt;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (dir_up | dir_dn) begin
              pos     <= sat_step(pos, dir_up, STEP, MAX);
              held_up <= dir_up;
              cnt     <= DELAY_LD;
              state   <= ST_HOLD;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (!dir_same) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else if (cnt == CNT_W'(1)) begin
              pos   <= sat_step(pos, held_up, STEP, MAX);
              cnt   <= RATE_LD;
              state <= ST_REPEAT;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_pos_ctl.sv
// Button-driven x/y position controller: input synchronizers, end-of-frame
// tick detection and two independent axis steppers.
module btn_pos_ctl
  import btn_pos_ctl_pkg::*;
#(
  parameter logic [POS_W-1:0] X_MAX        = 10'd639,
  parameter logic [POS_W-1:0] Y_MAX        = 10'd479,
  parameter logic [POS_W-1:0] X_INIT       = 10'd0,
  parameter logic [POS_W-1:0] Y_INIT       = 10'd0,
  parameter logic [POS_W-1:0] STEP         = 10'd1,
  parameter int               DEB_FRAMES   = 2,
  parameter int               REPEAT_DELAY = 24,
  parameter int               REPEAT_RATE  = 4
) (
  input  logic             px_clk,
  input  logic             reset,
  input  logic             endframe,
  input  logic             btn_x_up,
  input  logic             btn_x_down,
  input  logic             btn_y_up,
  input  logic             btn_y_down,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             moving
);

  // Bit order: {endframe, x_up, x_down, y_up, y_down}
  logic [4:0] sync1, sync2;
  logic       ef_prev;
  logic       tick;
  logic       x_act, y_act;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      ef_prev <= 1'b0;
    end else begin
      sync1   <= {endframe, btn_x_up, btn_x_down, btn_y_up, btn_y_down};
      sync2   <= sync1;
      ef_prev <= sync2[4];
    end
  end

  assign tick   = sync2[4] & ~ef_prev;
  assign moving = x_act | y_act;

  btn_axis_step #(
    .MAX(X_MAX), .INIT(X_INIT), .STEP(STEP), .DEB_FRAMES(DEB_FRAMES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_x_axis (
    .px_clk (px_clk),
    .reset  (reset),
    .tick   (tick),
    .raw_up (sync2[3]),
    .raw_dn (sync2[2]),
    .pos    (x_pos),
    .active (x_act)
  );

  btn_axis_step #(
    .MAX(Y_MAX), .INIT(Y_INIT), .STEP(STEP), .DEB_FRAMES(DEB_FRAMES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_y_axis (
    .px_clk (px_clk),
    .reset  (reset),
    .tick   (tick),
    .raw_up (sync2[1]),
    .raw_dn (sync2[0]),
    .pos    (y_pos),
    .active (y_act)
  );

endmodule

// File: tb/tb_btn_pos_ctl.sv
// Self-checking bench for btn_pos_ctl: a hand-derived frame table, cycle-level
// corner sequences and randomized frames checked against a frame-level model.
module tb_btn_pos_ctl;

  localparam int DEB = 2;
  localparam int DLY = 4;
  localparam int RTE = 2;

  logic       px_clk = 1'b0;
  logic       reset = 1'b1;
  logic       endframe = 1'b0;
  logic       btn_x_up = 1'b0, btn_x_down = 1'b0, btn_y_up = 1'b0, btn_y_down = 1'b0;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       mv_a, mv_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 px_clk = ~px_clk;

  btn_pos_ctl #(
    .X_INIT(10'd0), .Y_INIT(10'd5), .DEB_FRAMES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE)
  ) dut_a (
    .px_clk(px_clk), .reset(reset), .endframe(endframe),
    .btn_x_up(btn_x_up), .btn_x_down(btn_x_down), .btn_y_up(btn_y_up), .btn_y_down(btn_y_down),
    .x_pos(x_a), .y_pos(y_a), .moving(mv_a)
  );

  btn_pos_ctl #(
    .X_INIT(10'd638), .Y_INIT(10'd0), .DEB_FRAMES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE)
  ) dut_b (
    .px_clk(px_clk), .reset(reset), .endframe(endframe),
    .btn_x_up(btn_x_up), .btn_x_down(btn_x_down), .btn_y_up(btn_y_up), .btn_y_down(btn_y_down),
    .x_pos(x_b), .y_pos(y_b), .moving(mv_b)
  );

  // Frame-level reference: buttons index 0=x_up 1=x_down 2=y_up 3=y_down.
  int m_deb [4];
  int m_dcnt[4];
  int m_act [2];
  int m_up  [2];
  int m_age [2];
  int m_pos [2][2];   // [dut][axis]
  int m_init[2][2] = '{'{0, 5}, '{638, 0}};
  int m_max [2] = '{639, 479};

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_deb[i] = 0; m_dcnt[i] = 0; end
    for (int a = 0; a < 2; a++) begin
      m_act[a] = 0; m_up[a] = 0; m_age[a] = 0;
      for (int d = 0; d < 2; d++) m_pos[d][a] = m_init[d][a];
    end
  endtask

  // One tick: buttons must have held the given levels long enough to be synced.
  task automatic model_tick(input logic [3:0] b);
    int raw, dir, stp;
    for (int i = 0; i < 4; i++) begin
      raw = int'(b[3-i]);
      if (raw == m_deb[i]) m_dcnt[i] = 0;
      else begin
        m_dcnt[i]++;
        if (m_dcnt[i] == DEB) begin m_deb[i] = raw; m_dcnt[i] = 0; end
      end
    end
    for (int a = 0; a < 2; a++) begin
      dir = (m_deb[2*a] == 1 && m_deb[2*a+1] == 0) ? 1 :
            (m_deb[2*a+1] == 1 && m_deb[2*a] == 0) ? 2 : 0;
      stp = 0;
      if (m_act[a] == 0) begin
        if (dir != 0) begin
          m_act[a] = 1; m_up[a] = (dir == 1) ? 1 : 0; m_age[a] = 0; stp = 1;
        end
      end else if (dir != ((m_up[a] == 1) ? 1 : 2)) begin
        m_act[a] = 0;
      end else begin
        m_age[a]++;
        if (m_age[a] >= DLY && ((m_age[a] - DLY) % RTE) == 0) stp = 1;
      end
      if (stp == 1)
        for (int d = 0; d < 2; d++) begin
          if (m_up[a] == 1) m_pos[d][a] = (m_pos[d][a] + 1 > m_max[a]) ? m_max[a] : m_pos[d][a] + 1;
          else              m_pos[d][a] = (m_pos[d][a] < 1) ? 0 : m_pos[d][a] - 1;
        end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    int mv;
    mv = (m_act[0] != 0 || m_act[1] != 0) ? 1 : 0;
    check({tag, ".x_a"}, int'(x_a), m_pos[0][0]);
    check({tag, ".y_a"}, int'(y_a), m_pos[0][1]);
    check({tag, ".x_b"}, int'(x_b), m_pos[1][0]);
    check({tag, ".y_b"}, int'(y_b), m_pos[1][1]);
    check({tag, ".mv_a"}, int'(mv_a), mv);
    check({tag, ".mv_b"}, int'(mv_b), mv);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_x_up, btn_x_down, btn_y_up, btn_y_down} = b;
  endtask

  // One frame with a single endframe rise; with lat set, x_a is checked on
  // the cycles around the tick edge.
  task automatic frame(input logic [3:0] b, input bit lat);
    int old_x;
    old_x = m_pos[0][0];
    model_tick(b);
    set_btn(b);
    repeat (4) @(posedge px_clk);
    #1 endframe = 1'b1;
    if (lat) begin
      repeat (2) @(posedge px_clk);
      #1 check("lat_before_edge", int'(x_a), old_x);
      @(posedge px_clk);
      #1 check("lat_after_edge", int'(x_a), m_pos[0][0]);
      repeat (3) @(posedge px_clk);
    end else begin
      repeat (6) @(posedge px_clk);
    end
    #1 endframe = 1'b0;
    repeat (6) @(posedge px_clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge px_clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] b;
    int xa, ya, xb, yb, mv;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] b, input int xa, input int ya,
                              input int xb, input int yb, input int mv);
    vec_t v;
    v.b = b; v.xa = xa; v.ya = ya; v.xb = xb; v.yb = yb; v.mv = mv;
    return v;
  endfunction

  vec_t vecs[22];
  logic [3:0] rb;

  initial begin
    // {x_up, x_down, y_up, y_down} per frame and the state after its tick.
    vecs[0]  = mk(4'b1001, 0, 5, 638, 0, 0);
    vecs[1]  = mk(4'b1001, 1, 4, 639, 0, 1);
    vecs[2]  = mk(4'b1001, 1, 4, 639, 0, 1);
    vecs[3]  = mk(4'b1001, 1, 4, 639, 0, 1);
    vecs[4]  = mk(4'b1001, 1, 4, 639, 0, 1);
    vecs[5]  = mk(4'b1001, 2, 3, 639, 0, 1);
    vecs[6]  = mk(4'b1001, 2, 3, 639, 0, 1);
    vecs[7]  = mk(4'b1001, 3, 2, 639, 0, 1);
    vecs[8]  = mk(4'b1001, 3, 2, 639, 0, 1);
    vecs[9]  = mk(4'b1001, 4, 1, 639, 0, 1);
    vecs[10] = mk(4'b0000, 4, 1, 639, 0, 1);
    vecs[11] = mk(4'b0000, 4, 1, 639, 0, 0);
    vecs[12] = mk(4'b0010, 4, 1, 639, 0, 0);
    vecs[13] = mk(4'b0000, 4, 1, 639, 0, 0);
    vecs[14] = mk(4'b1100, 4, 1, 639, 0, 0);
    vecs[15] = mk(4'b1100, 4, 1, 639, 0, 0);
    vecs[16] = mk(4'b1100, 4, 1, 639, 0, 0);
    vecs[17] = mk(4'b1000, 4, 1, 639, 0, 0);
    vecs[18] = mk(4'b1000, 5, 1, 639, 0, 1);
    vecs[19] = mk(4'b1000, 5, 1, 639, 0, 1);
    vecs[20] = mk(4'b0000, 5, 1, 639, 0, 1);
    vecs[21] = mk(4'b0000, 5, 1, 639, 0, 0);

    repeat (3) @(posedge px_clk);
    #1 reset = 1'b0;
    model_reset();
    check("rst.x_a", int'(x_a), 0);
    check("rst.y_a", int'(y_a), 5);
    check("rst.x_b", int'(x_b), 638);
    check("rst.y_b", int'(y_b), 0);
    check("rst.mv_a", int'(mv_a), 0);
    check("rst.mv_b", int'(mv_b), 0);

    for (int i = 0; i < 22; i++) begin
      frame(vecs[i].b, 1'b0);
      check($sformatf("vec%0d.x_a", i), int'(x_a), vecs[i].xa);
      check($sformatf("vec%0d.y_a", i), int'(y_a), vecs[i].ya);
      check($sformatf("vec%0d.x_b", i), int'(x_b), vecs[i].xb);
      check($sformatf("vec%0d.y_b", i), int'(y_b), vecs[i].yb);
      check($sformatf("vec%0d.mv_a", i), int'(mv_a), vecs[i].mv);
    end
    compare_model("after_table");

    // Output changes exactly one cycle after the tick edge.
    frame(4'b1000, 1'b0);
    frame(4'b1000, 1'b1);
    check("lat_step.x_a", int'(x_a), 6);
    for (int i = 0; i < 3; i++) begin
      frame(4'b1000, 1'b0);
      compare_model("hold");
    end

    // Reset sampled on the very edge that would apply a tick.
    set_btn(4'b1000);
    repeat (4) @(posedge px_clk);
    #1 endframe = 1'b1;
    repeat (2) @(posedge px_clk);
    #1 begin reset = 1'b1; endframe = 1'b0; end
    @(posedge px_clk);
    #1 reset = 1'b0;
    model_reset();
    check("mid_rst.x_a", int'(x_a), 0);
    check("mid_rst.mv_a", int'(mv_a), 0);
    check("mid_rst.x_b", int'(x_b), 638);
    repeat (6) @(posedge px_clk);
    #1;

    // endframe held high across three frames gives a single tick.
    repeat (4) @(posedge px_clk);
    #1 endframe = 1'b1;
    repeat (48) @(posedge px_clk);
    #1 endframe = 1'b0;
    repeat (6) @(posedge px_clk);
    #1;
    model_tick(4'b1000);
    check("long_ef.x_a", int'(x_a), 0);
    check("long_ef.mv_a", int'(mv_a), 0);
    frame(4'b1000, 1'b0);
    check("post_rst_step.x_a", int'(x_a), 1);
    check("post_rst_step.mv_a", int'(mv_a), 1);
    compare_model("post_rst");

    rb = 4'b0000;
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 4) == 0) rb[i] = ~rb[i];
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset();
        compare_model("rnd_rst");
      end
      frame(rb, 1'b0);
      compare_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
